// File: rtl/spi_reg_sequencer_if.sv
// Request/response and engine-frame bundle between the register sequencer, its requester and the SPI engine.
interface spi_reg_sequencer_if #(
  parameter int unsigned ADDR_WIDTH     = 7,
  parameter int unsigned REG_DATA_WIDTH = 8,
  parameter int unsigned SPI_DATA_WIDTH = 32,
  parameter int unsigned LEN_WIDTH      = 8
);
  logic                      req_valid;
  logic                      req_ready;
  logic                      req_rw;
  logic [ADDR_WIDTH-1:0]     req_addr;
  logic [REG_DATA_WIDTH-1:0] req_wdata;
  logic                      resp_valid;
  logic                      resp_ready;
  logic [REG_DATA_WIDTH-1:0] resp_rdata;
  logic                      resp_error;
  logic                      txn_valid;
  logic                      txn_ready;
  logic [LEN_WIDTH-1:0]      txn_length;
  logic [SPI_DATA_WIDTH-1:0] txn_data;
  logic [SPI_DATA_WIDTH-1:0] txn_rw_mask;
  logic                      rsp_valid;
  logic [SPI_DATA_WIDTH-1:0] rsp_data;

  // Requester + engine side
  modport master (
    output req_valid, req_rw, req_addr, req_wdata, resp_ready, txn_ready, rsp_valid, rsp_data,
    input  req_ready, resp_valid, resp_rdata, resp_error, txn_valid, txn_length, txn_data, txn_rw_mask
  );

  // Sequencer side
  modport slave (
    input  req_valid, req_rw, req_addr, req_wdata, resp_ready, txn_ready, rsp_valid, rsp_data,
    output req_ready, resp_valid, resp_rdata, resp_error, txn_valid, txn_length, txn_data, txn_rw_mask
  );
endinterface

// File: rtl/spi_reg_sequencer.sv
// Register read/write command stage for the half-duplex SPI engine: frames one request at a time,
// waits for the read word (with timeout) and enforces a minimum idle gap between frames.
module spi_reg_sequencer #(
  parameter int unsigned ADDR_WIDTH     = 7,
  parameter int unsigned REG_DATA_WIDTH = 8,
  parameter int unsigned SPI_DATA_WIDTH = 32,
  parameter int unsigned LEN_WIDTH      = 8,
  parameter int unsigned GAP_CYCLES     = 4,
  parameter int unsigned TIMEOUT_CYCLES = 4096
) (
  input  logic                fabric_clk,
  input  logic                reset_n,
  spi_reg_sequencer_if.slave  bus,
  output logic                param_error,
  output logic                stray_rsp
);

  localparam int unsigned FRAME_LEN = 1 + ADDR_WIDTH + REG_DATA_WIDTH;
  localparam bit          PARAM_BAD = (SPI_DATA_WIDTH < FRAME_LEN);
  localparam int unsigned TMR_W     = $clog2(TIMEOUT_CYCLES + 2);
  localparam int unsigned GAP_W     = $clog2(GAP_CYCLES + 2);
  localparam logic [TMR_W-1:0] TMR_MAX = TMR_W'(TIMEOUT_CYCLES);
  localparam logic [GAP_W-1:0] GAP_MAX = GAP_W'(GAP_CYCLES);

  typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_WAIT_RSP, S_RESPOND, S_GAP} state_t;

  state_t                    state_q, state_d;
  logic                      req_ready_q, req_ready_d;
  logic                      rw_q, rw_d;
  logic                      txn_valid_q, txn_valid_d;
  logic [LEN_WIDTH-1:0]      txn_length_q, txn_length_d;
  logic [SPI_DATA_WIDTH-1:0] txn_data_q, txn_data_d;
  logic [SPI_DATA_WIDTH-1:0] txn_mask_q, txn_mask_d;
  logic                      resp_valid_q, resp_valid_d;
  logic [REG_DATA_WIDTH-1:0] resp_rdata_q, resp_rdata_d;
  logic                      resp_error_q, resp_error_d;
  logic                      stray_q, stray_d;
  logic [TMR_W-1:0]          timer_q, timer_d;
  logic [GAP_W-1:0]          gap_q, gap_d;

  // Frame bits {rw, addr, data}; the data field is zero on reads
  function automatic logic [SPI_DATA_WIDTH-1:0] frame_data(input logic rw,
                                                           input logic [ADDR_WIDTH-1:0] addr,
                                                           input logic [REG_DATA_WIDTH-1:0] wdata);
    logic [REG_DATA_WIDTH-1:0] wfield;
    wfield = rw ? '0 : wdata;
    return (SPI_DATA_WIDTH'(rw) << (FRAME_LEN - 1)) |
           (SPI_DATA_WIDTH'(addr) << REG_DATA_WIDTH) |
           SPI_DATA_WIDTH'(wfield);
  endfunction

  // Drive rw+addr always; drive the data field only on writes so reads sample it
  function automatic logic [SPI_DATA_WIDTH-1:0] frame_mask(input logic rw);
    logic [SPI_DATA_WIDTH-1:0] m;
    for (int unsigned i = 0; i < SPI_DATA_WIDTH; i++) begin
      m[i] = (i < FRAME_LEN) && ((i >= REG_DATA_WIDTH) || !rw);
    end
    return m;
  endfunction

  always_comb begin
    state_d      = state_q;
    rw_d         = rw_q;
    txn_valid_d  = txn_valid_q;
    txn_length_d = txn_length_q;
    txn_data_d   = txn_data_q;
    txn_mask_d   = txn_mask_q;
    resp_valid_d = resp_valid_q;
    resp_rdata_d = resp_rdata_q;
    resp_error_d = resp_error_q;
    timer_d      = timer_q;
    gap_d        = gap_q;
    stray_d      = stray_q | (bus.rsp_valid && (state_q != S_WAIT_RSP));

    case (state_q)
      S_IDLE: begin
        if (bus.req_valid && req_ready_q) begin
          rw_d         = bus.req_rw;
          txn_data_d   = frame_data(bus.req_rw, bus.req_addr, bus.req_wdata);
          txn_mask_d   = frame_mask(bus.req_rw);
          txn_length_d = LEN_WIDTH'(FRAME_LEN);
          txn_valid_d  = 1'b1;
          state_d      = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (bus.txn_ready) begin
          txn_valid_d = 1'b0;
          timer_d     = '0;
          state_d     = S_WAIT_RSP;
        end
      end
      S_WAIT_RSP: begin
        // A reply arriving on the timeout cycle still counts as a normal response
        if (bus.rsp_valid) begin
          resp_valid_d = 1'b1;
          resp_rdata_d = rw_q ? bus.rsp_data[REG_DATA_WIDTH-1:0] : '0;
          resp_error_d = 1'b0;
          state_d      = S_RESPOND;
        end else if (timer_q >= (TMR_MAX - TMR_W'(1))) begin
          resp_valid_d = 1'b1;
          resp_rdata_d = '0;
          resp_error_d = 1'b1;
          state_d      = S_RESPOND;
        end else if (timer_q < TMR_MAX) begin
          timer_d = timer_q + TMR_W'(1);
        end
      end
      S_RESPOND: begin
        if (bus.resp_ready) begin
          resp_valid_d = 1'b0;
          gap_d        = GAP_MAX;
          state_d      = (GAP_CYCLES == 0) ? S_IDLE : S_GAP;
        end
      end
      S_GAP: begin
        if (gap_q > GAP_W'(1)) begin
          gap_d = gap_q - GAP_W'(1);
        end else begin
          gap_d   = '0;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    req_ready_d = (state_d == S_IDLE) && !PARAM_BAD;
  end

  always_ff @(posedge fabric_clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= S_IDLE;
      req_ready_q  <= 1'b0;
      rw_q         <= 1'b0;
      txn_valid_q  <= 1'b0;
      txn_length_q <= '0;
      txn_data_q   <= '0;
      txn_mask_q   <= '0;
      resp_valid_q <= 1'b0;
      resp_rdata_q <= '0;
      resp_error_q <= 1'b0;
      stray_q      <= 1'b0;
      timer_q      <= '0;
      gap_q        <= '0;
    end else begin
      state_q      <= state_d;
      req_ready_q  <= req_ready_d;
      rw_q         <= rw_d;
      txn_valid_q  <= txn_valid_d;
      txn_length_q <= txn_length_d;
      txn_data_q   <= txn_data_d;
      txn_mask_q   <= txn_mask_d;
      resp_valid_q <= resp_valid_d;
      resp_rdata_q <= resp_rdata_d;
      resp_error_q <= resp_error_d;
      stray_q      <= stray_d;
      timer_q      <= timer_d;
      gap_q        <= gap_d;
    end
  end

  assign bus.req_ready   = req_ready_q;
  assign bus.txn_valid   = txn_valid_q;
  assign bus.txn_length  = txn_length_q;
  assign bus.txn_data    = txn_data_q;
  assign bus.txn_rw_mask = txn_mask_q;
  assign bus.resp_valid  = resp_valid_q;
  assign bus.resp_rdata  = resp_rdata_q;
  assign bus.resp_error  = resp_error_q;
  assign stray_rsp       = stray_q;
  assign param_error     = PARAM_BAD;

endmodule
